// File: rtl/memio_pkg.sv
// Shared definitions for the screen-memory fill path: memory geometry,
// fill-controller state encoding and a cell-to-byte-address helper.
package memio_pkg;

    // Number of character cells in screen memory.
    localparam int SMEM_LOC = 1200;

    // Byte address of cell 0; each cell occupies one 32-bit word.
    localparam logic [31:0] SMEM_BASE = 32'h0002_0000;

    // Bus data width shared by the CPU and fill sources.
    localparam int DATA_W = 32;

    // Cell index width (covers 0..2047) and the one-bit-wider range width
    // used so start+count never wraps back to a low index.
    localparam int IDX_W = 11;
    localparam int RNG_W = 12;

    // Character code width.
    localparam int CHAR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } fill_state_e;

    // Byte address of a cell: base plus the index scaled to words.
    function automatic logic [DATA_W-1:0] cell_addr(
        input logic [DATA_W-1:0] base,
        input logic [IDX_W-1:0]  idx
    );
        return base + {{(DATA_W-IDX_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/memio_bus_mux.sv
// Memory-mapped IO bus mux. The CPU always owns the bus when it issues a
// request; otherwise a pending fill write takes it; otherwise the CPU
// signals pass straight through.
module memio_bus_mux
    import memio_pkg::*;
(
    input  logic              cpu_req_i,
    input  logic              fill_req_i,
    input  logic [DATA_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_wr_i,
    input  logic [DATA_W-1:0] fill_addr_i,
    input  logic [DATA_W-1:0] fill_wdata_i,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_wr_o
);

    // Combinational source select; CPU is the default owner.
    always_comb begin
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_wr_o    = cpu_wr_i;
        if (!cpu_req_i && fill_req_i) begin
            mem_addr_o  = fill_addr_i;
            mem_wdata_o = fill_wdata_i;
            mem_wr_o    = 1'b1;
        end
    end

endmodule

// File: rtl/smem_fill_ctrl.sv
// Screen-memory fill controller. Writes one character code into a range of
// screen cells, one cell per free bus cycle, yielding to the CPU whenever it
// requests the bus. Out-of-range requests are rejected or clipped and flagged
// in a sticky error bit. done pulses in the cycle after FINISH, so an
// unblocked N-cell fill reports done N+2 cycles after go.
module smem_fill_ctrl
    import memio_pkg::*;
#(
    parameter int          SMEM_LOC  = memio_pkg::SMEM_LOC,
    parameter logic [31:0] SMEM_BASE = memio_pkg::SMEM_BASE
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_writedata,
    input  logic              cpu_wr,
    input  logic              cpu_req,
    input  logic              fill_go,
    input  logic              fill_abort,
    input  logic [IDX_W-1:0]  fill_start,
    input  logic [IDX_W-1:0]  fill_count,
    input  logic [CHAR_W-1:0] fill_char,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_writedata,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              fill_err
);

    localparam logic [RNG_W-1:0] LOC_R    = RNG_W'(SMEM_LOC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SMEM_LOC - 1);

    fill_state_e       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  end_q;
    logic [CHAR_W-1:0] char_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // Range decode of the incoming request, evaluated in 12 bits.
    logic [RNG_W-1:0]  start_ext;
    logic [RNG_W-1:0]  sum_ext;
    logic              start_oob;
    logic              clip_d;
    logic [IDX_W-1:0]  end_d;

    // Fill-side bus request.
    logic              fill_req;
    logic [31:0]       fill_addr;
    logic [31:0]       fill_wdata;

    // Decode start/end of the requested range, clipping at the last cell.
    always_comb begin
        start_ext = {1'b0, fill_start};
        sum_ext   = start_ext + {1'b0, fill_count};
        start_oob = (start_ext >= LOC_R);
        clip_d    = (sum_ext > LOC_R);
        end_d     = clip_d ? LAST_IDX : IDX_W'(sum_ext - RNG_W'(1));
    end

    // Control FSM with registered busy/done/error outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            end_q   <= '0;
            char_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // go wins over a simultaneous abort; abort alone is ignored here.
                    if (fill_go) begin
                        char_q <= fill_char;
                        idx_q  <= fill_start;
                        end_q  <= end_d;
                        busy_q <= 1'b1;
                        if (start_oob) begin
                            err_q   <= 1'b1;
                            state_q <= ST_FINISH;
                        end else if (fill_count == '0) begin
                            err_q   <= 1'b0;
                            state_q <= ST_FINISH;
                        end else begin
                            err_q   <= clip_d;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (fill_abort) begin
                        state_q <= ST_FINISH;
                    end else if (!cpu_req) begin
                        // A CPU-held cycle leaves idx unchanged so the same cell is retried.
                        if (idx_q == end_q) begin
                            state_q <= ST_FINISH;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Fill write request for the current cell; an abort cycle writes nothing.
    always_comb begin
        fill_req   = (state_q == ST_RUN) && !fill_abort;
        fill_addr  = cell_addr(SMEM_BASE, idx_q);
        fill_wdata = {{(32-CHAR_W){1'b0}}, char_q};
    end

    memio_bus_mux u_mux (
        .cpu_req_i    (cpu_req),
        .fill_req_i   (fill_req),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_writedata),
        .cpu_wr_i     (cpu_wr),
        .fill_addr_i  (fill_addr),
        .fill_wdata_i (fill_wdata),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_writedata),
        .mem_wr_o     (mem_wr)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign fill_err = err_q;

endmodule
